// File: rtl/dmem_wbuf.sv
// Posted-store write buffer between the core data port and dmem, with store-to-load forwarding.
// Define WBUF_FWD_EN to forward load hits from the buffer; otherwise load hits stall until drained.
module dmem_wbuf #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_we,
   input  logic          cpu_re,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          stall,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   input  logic [DW-1:0] mem_rdata,
   output logic          wb_empty
);

   localparam int            PW      = $clog2(DEPTH);
   localparam int            IW      = AW - 2;
   localparam logic [PW:0]   C_DEPTH = (PW+1)'(DEPTH);

   logic [IW-1:0]    r_addr [DEPTH];
   logic [DW-1:0]    r_data [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [PW:0]      r_count;

   logic             w_full;
   logic             w_load;
   logic             w_hit;
   logic             w_fwd;
   logic             w_ld_stall;
   logic             w_load_owns;
   logic             w_push;
   logic             w_pop;
   logic [DEPTH-1:0] w_match;

   assign w_full = (r_count == C_DEPTH);
   assign w_load = cpu_re & ~cpu_we;

   // A slot is live when its distance from head is below the occupancy.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_match
         logic [PW-1:0] w_age;
         assign w_age       = PW'(gi) - r_head;
         assign w_match[gi] = ({1'b0, w_age} < r_count) &&
                              (r_addr[gi] == cpu_addr[AW-1:2]);
      end
   endgenerate

   assign w_hit = |w_match;

`ifdef WBUF_FWD_EN
   logic [DW-1:0] w_fwd_data;

   // Scan oldest to youngest so the youngest matching store wins.
   always_comb begin
      logic [PW-1:0] idx;
      w_fwd_data = '0;
      idx        = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = r_head + PW'(k);
         if (w_match[idx]) begin
            w_fwd_data = r_data[idx];
         end
      end
   end

   assign w_fwd      = w_load & w_hit;
   assign w_ld_stall = 1'b0;
   assign cpu_rdata  = w_fwd ? w_fwd_data : mem_rdata;
`else
   assign w_fwd      = 1'b0;
   assign w_ld_stall = w_load & w_hit;
   assign cpu_rdata  = mem_rdata;
`endif

   assign w_load_owns = w_load & ~w_fwd & ~w_ld_stall;
   // A pop in this cycle never frees a slot for this cycle's push.
   assign w_push      = cpu_we & ~w_full;
   assign w_pop       = (r_count != '0) & mem_ready & ~w_load_owns;

   assign stall     = (cpu_we & w_full) | w_ld_stall;
   assign mem_we    = w_pop;
   assign mem_addr  = w_pop ? {r_addr[r_head], 2'b00} : cpu_addr;
   assign mem_wdata = r_data[r_head];
   assign wb_empty  = (r_count == '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= cpu_addr[AW-1:2];
         r_data[r_tail] <= cpu_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Self-checking bench for dmem_wbuf: directed scenarios plus random traffic against a queue-based model.
// Expectations follow WBUF_FWD_EN when it is defined for the build.
module tb_dmem_wbuf;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        cpu_we;
   logic        cpu_re;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        stall;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        wb_empty;

   dmem_wbuf #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_we    (cpu_we),
      .cpu_re    (cpu_re),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .stall     (stall),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .wb_empty  (wb_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // dmem stand-in: combinational read, write on the rising edge
   logic [31:0] dmem [256];
   assign mem_rdata = dmem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;
   end

   // Reference: pending stores as a queue, memory contents as an array
   typedef struct {
      logic [29:0] wi;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   logic [31:0] refmem [256];

   int          n_cmp = 0;
   int          n_err = 0;
   logic        last_stall = 1'b0;
   logic [31:0] last_rdata = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check at the falling edge, advance the model, wait for the edge.
   task automatic cyc(input logic we, input logic re, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
      logic        full, hit, ld, fwd, lst, own, pop, e_stall;
      logic [31:0] yd;
      cpu_we    = we;
      cpu_re    = re;
      cpu_addr  = a;
      cpu_wdata = d;
      mem_ready = rdy;
      #4;
      full = (q.size() == DEPTH);
      hit  = 1'b0;
      yd   = '0;
      foreach (q[i]) begin
         if (q[i].wi == a[31:2]) begin
            hit = 1'b1;
            yd  = q[i].d;
         end
      end
      ld = re && !we;
`ifdef WBUF_FWD_EN
      fwd = ld && hit;
      lst = 1'b0;
`else
      fwd = 1'b0;
      lst = ld && hit;
`endif
      own     = ld && !fwd && !lst;
      pop     = (q.size() > 0) && rdy && !own;
      e_stall = (we && full) || lst;

      chk("stall", {31'b0, stall}, {31'b0, e_stall});
      chk("mem_we", {31'b0, mem_we}, {31'b0, pop});
      chk("wb_empty", {31'b0, wb_empty}, {31'b0, q.size() == 0});
      if (pop) begin
         chk("mem_addr_drain", mem_addr, {q[0].wi, 2'b00});
         chk("mem_wdata", mem_wdata, q[0].d);
      end else begin
         chk("mem_addr_pass", mem_addr, a);
      end
      if (fwd)      chk("rdata_fwd", cpu_rdata, yd);
      else if (own) chk("rdata_mem", cpu_rdata, refmem[a[9:2]]);

      $display("cyc we=%0d re=%0d addr=%h wdata=%h rdy=%0d | stall=%0d mem_we=%0d mem_addr=%h rdata=%h pend=%0d",
               we, re, a, d, rdy, stall, mem_we, mem_addr, cpu_rdata, q.size());

      last_stall = e_stall;
      last_rdata = cpu_rdata;
      if (pop) begin
         refmem[q[0].wi[7:0]] = q[0].d;
         void'(q.pop_front());
      end
      if (we && !full) q.push_back('{a[31:2], d});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
   endtask

   initial begin
      int          n_st;
      logic [31:0] pa, pd;
      logic        pw, pr;

      reset     = 1'b0;
      cpu_we    = 1'b0;
      cpu_re    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      mem_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         dmem[i]   = $urandom;
         refmem[i] = dmem[i];
      end

      // Reset state
      @(posedge clk);
      #4;
      chk("rst_wb_empty", {31'b0, wb_empty}, 32'd1);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Store then drain
      cyc(1'b1, 1'b0, 32'h40, 32'h1234, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      chk("sd_dmem_0x10", dmem[16], 32'h1234);
      chk("sd_empty", {31'b0, wb_empty}, 32'd1);

      // Full with mem_ready low, then release
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h100 + 32'(i*4), 32'hF000 + 32'(i), 1'b0);
      chk("full_5th_stall", {31'b0, last_stall}, 32'd1);
      n_st = 0;
      for (int i = 0; i < 10 && last_stall; i++) begin
         cyc(1'b1, 1'b0, 32'h110, 32'hF004, 1'b1);
         if (last_stall) n_st++;
      end
      chk("full_stall_cycles", n_st, 32'd1);
      idle(6);
      chk("full_order_last", dmem[32'h110 >> 2], 32'hF004);

`ifdef WBUF_FWD_EN
      // Forwarding of the youngest matching store
      cyc(1'b1, 1'b0, 32'h80, 32'hA, 1'b0);
      cyc(1'b1, 1'b0, 32'h80, 32'hB, 1'b0);
      cyc(1'b0, 1'b1, 32'h80, 32'h0, 1'b0);
      chk("fwd_rdata", last_rdata, 32'hB);
      chk("fwd_stall", {31'b0, last_stall}, 32'd0);
      idle(4);
`endif

      // Load hit with the drain running
      cyc(1'b1, 1'b0, 32'h84, 32'hA, 1'b1);
      cyc(1'b1, 1'b0, 32'h84, 32'hB, 1'b1);
      last_stall = 1'b1;
      for (int i = 0; i < 10 && last_stall; i++) cyc(1'b0, 1'b1, 32'h84, 32'h0, 1'b1);
      chk("hit_rdata", last_rdata, 32'hB);
      chk("hit_done", {31'b0, last_stall}, 32'd0);

      // Load misses hold off the drain
      cyc(1'b1, 1'b0, 32'hC0, 32'h11, 1'b0);
      cyc(1'b1, 1'b0, 32'hC4, 32'h22, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'h200 + 32'(i*4), 32'h0, 1'b1);
      chk("miss_pending", {31'b0, wb_empty}, 32'd0);
      idle(3);

      // Reset in the middle of a drain
      cyc(1'b1, 1'b0, 32'h140, 32'h51, 1'b0);
      cyc(1'b1, 1'b0, 32'h144, 32'h52, 1'b0);
      cyc(1'b1, 1'b0, 32'h148, 32'h53, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      reset     = 1'b0;
      mem_ready = 1'b1;
      q.delete();
      #1;
      chk("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("mid_rst_empty", {31'b0, wb_empty}, 32'd1);
      chk("mid_rst_stall", {31'b0, stall}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(4);
      chk("mid_rst_no_write", dmem[32'h144 >> 2], refmem[32'h144 >> 2]);

      // Random traffic; a stalled request is re-presented unchanged
      pw = 1'b0; pr = 1'b0; pa = '0; pd = '0;
      for (int i = 0; i < 400; i++) begin
         if (!last_stall) begin
            case ($urandom_range(0, 3))
               0:       begin pw = 1'b0; pr = 1'b0; end
               1:       begin pw = 1'b1; pr = 1'b0; end
               2:       begin pw = 1'b0; pr = 1'b1; end
               default: begin pw = 1'b1; pr = 1'b1; end
            endcase
            pa = 32'($urandom_range(0, 15)) << 2;
            pd = $urandom;
         end
         cyc(pw, pr, pa, pd, $urandom_range(0, 3) != 0);
      end

      for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
      chk("final_empty", {31'b0, wb_empty}, 32'd1);
      for (int i = 0; i < 256; i++) chk("final_mem", dmem[i], refmem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
